vector_ops_pipe: RTL and testbench

Parametrised, registered successor to our combinational vector-operations block. Takes two WIDTH-bit operands per beat over a valid/ready stream, applies one of eight selectable operations (bitwise, logical, reduction, inverted concatenation, packet accumulate), and presents the result through a one-deep output register with backpressure. Sits between an operand source and any consumer needing per-beat vector results or a whole-packet OR-accumulation.

---
 rtl/vector_ops_pipe.sv | 131 +++++++++++++
 tb/tb_vector_ops_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vector_ops_pipe.sv
// Registered vector-operations stage: two WIDTH-bit operands per beat in, one 2*WIDTH-bit
// result per producing beat out, with an op-7 OR-accumulate across a packet.
module vector_ops_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           in_op,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_vec,
    output logic                 out_flag,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_last
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]           state_reg, state_next;
    logic [WIDTH-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;

    logic                 out_valid_reg;
    logic [2*WIDTH-1:0]   out_vec_reg, vec_next;
    logic                 out_flag_reg;
    logic [CNT_W-1:0]     out_count_reg, count_next;
    logic                 out_last_reg, last_next;

    logic [WIDTH-1:0]     and_ab, or_ab, xor_ab;
    logic [WIDTH-1:0]     acc_merge;
    logic [CNT_W-1:0]     cnt_sat, cnt_merge;
    logic                 accept, produce;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_ab[gi] = in_a[gi] & in_b[gi];
            assign or_ab[gi]  = in_a[gi] | in_b[gi];
            assign xor_ab[gi] = in_a[gi] ^ in_b[gi];
        end
    endgenerate

    // Accept whenever the output slot is empty or being drained this cycle.
    assign in_ready = !reset && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    // Beat counter sticks at its maximum rather than wrapping.
    assign cnt_sat   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
    assign acc_merge = (state_reg == ST_ACCUM) ? (acc_reg | and_ab) : and_ab;
    assign cnt_merge = (state_reg == ST_ACCUM) ? cnt_sat : CNT_ONE;

    always_comb begin
        vec_next   = '0;
        count_next = CNT_ONE;
        last_next  = in_last;
        produce    = 1'b1;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        state_next = state_reg;
        case (in_op)
            3'd0: vec_next[WIDTH-1:0] = and_ab;
            3'd1: vec_next[WIDTH-1:0] = or_ab;
            3'd2: vec_next[WIDTH-1:0] = xor_ab;
            3'd3: vec_next = {~in_a, ~in_b};
            3'd4: vec_next[0] = (|in_a) && (|in_b);
            3'd5: vec_next[0] = (|in_a) || (|in_b);
            3'd6: vec_next[3:0] = {&in_b, &in_a, |in_b, |in_a};
            default: begin
                // Op 7: only the closing beat of a packet yields a result.
                if (in_last) begin
                    vec_next[WIDTH-1:0] = acc_merge;
                    count_next          = cnt_merge;
                    last_next           = 1'b1;
                    acc_next            = '0;
                    cnt_next            = '0;
                    state_next          = ST_IDLE;
                end else begin
                    produce    = 1'b0;
                    acc_next   = acc_merge;
                    cnt_next   = cnt_merge;
                    state_next = ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_vec_reg   <= '0;
            out_flag_reg  <= 1'b0;
            out_count_reg <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            if (accept) begin
                state_reg <= state_next;
                acc_reg   <= acc_next;
                cnt_reg   <= cnt_next;
            end
            if (accept && produce) begin
                out_valid_reg <= 1'b1;
                out_vec_reg   <= vec_next;
                out_flag_reg  <= |vec_next;
                out_count_reg <= count_next;
                out_last_reg  <= last_next;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_vec   = out_vec_reg;
    assign out_flag  = out_flag_reg;
    assign out_count = out_count_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_vector_ops_pipe.sv
// Directed-vector bench for vector_ops_pipe (WIDTH=4, CNT_W=2) with a queue scoreboard
// and a negedge monitor that pops an expectation for every output transfer.
module tb_vector_ops_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b;
    logic [2:0] in_op;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_vec;
    logic       out_flag;
    logic [1:0] out_count;
    logic       out_last;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [7:0] vec;
        logic [1:0] cnt;
        logic       last;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    vector_ops_pipe #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_flag(out_flag),
        .out_count(out_count), .out_last(out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got vec=%0h, expected no output", out_vec);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_vec", 32'(out_vec), 32'(e.vec));
                chk("out_flag", 32'(out_flag), 32'(|e.vec));
                chk("out_count", 32'(out_count), 32'(e.cnt));
                chk("out_last", 32'(out_last), 32'(e.last));
                $display("out: vec=%02h flag=%0d count=%0d last=%0d", out_vec, out_flag, out_count, out_last);
            end
        end
    end

    // Present one beat (inputs change 1ns after posedge), wait for acceptance, log expectation.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic last, input logic prod, input logic [7:0] ev, input logic [1:0] ec);
        int n;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_last = last;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        if (prod) sb_q.push_back('{vec: ev, cnt: ec, last: last});
        $display("in: op=%0d a=%h b=%h last=%0d", op, a, b, last);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_vec", 32'(out_vec), 0);
        chk("rst_out_flag", 32'(out_flag), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Ops 0..6 back to back with a=1100, b=1010.
        send(4'hC, 4'hA, 3'd0, 1'b0, 1'b1, 8'h08, 2'd1);
        send(4'hC, 4'hA, 3'd1, 1'b0, 1'b1, 8'h0E, 2'd1);
        send(4'hC, 4'hA, 3'd2, 1'b0, 1'b1, 8'h06, 2'd1);
        send(4'hC, 4'hA, 3'd3, 1'b1, 1'b1, 8'h35, 2'd1);
        send(4'hC, 4'hA, 3'd4, 1'b0, 1'b1, 8'h01, 2'd1);
        send(4'hC, 4'hA, 3'd5, 1'b0, 1'b1, 8'h01, 2'd1);
        send(4'hC, 4'hA, 3'd6, 1'b0, 1'b1, 8'h03, 2'd1);
        // Zero-result corners: flag must be 0.
        send(4'h5, 4'hA, 3'd0, 1'b0, 1'b1, 8'h00, 2'd1);
        send(4'h0, 4'hA, 3'd4, 1'b0, 1'b1, 8'h00, 2'd1);
        send(4'h0, 4'h0, 3'd5, 1'b0, 1'b1, 8'h00, 2'd1);
        send(4'h3, 4'hC, 3'd6, 1'b0, 1'b1, 8'h03, 2'd1);
        drain_wait();

        // Op-7 packet of three beats.
        send(4'h1, 4'h1, 3'd7, 1'b0, 1'b0, 8'h00, 2'd0);
        send(4'h4, 4'h4, 3'd7, 1'b0, 1'b0, 8'h00, 2'd0);
        send(4'h8, 4'h8, 3'd7, 1'b1, 1'b1, 8'h0D, 2'd3);
        drain_wait();

        // Stall: hold out_ready low for 5 cycles with a result pending.
        out_ready = 1'b0;
        send(4'h3, 4'h5, 3'd2, 1'b0, 1'b1, 8'h06, 2'd1);
        in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF; in_op = 3'd7; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out_vec", 32'({out_valid, out_vec}), 32'h106);
            chk("stall_out_meta", 32'({out_flag, out_count, out_last}), 32'b1_01_0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready_while_valid", 32'({in_ready, out_valid}), 32'b11);
        // If the blocked op-7 beat had leaked in, this would come out as 0F/count 2.
        send(4'h3, 4'h1, 3'd7, 1'b1, 1'b1, 8'h01, 2'd1);
        drain_wait();

        // Saturating count: 6-beat packet with a 2-bit counter.
        for (int i = 0; i < 5; i++) send(4'h1, 4'h1, 3'd7, 1'b0, 1'b0, 8'h00, 2'd0);
        send(4'h1, 4'h1, 3'd7, 1'b1, 1'b1, 8'h01, 2'd3);
        drain_wait();

        // Op-2 beat inside an accumulate packet.
        send(4'h2, 4'h2, 3'd7, 1'b0, 1'b0, 8'h00, 2'd0);
        send(4'hC, 4'hA, 3'd2, 1'b0, 1'b1, 8'h06, 2'd1);
        send(4'h1, 4'h1, 3'd7, 1'b1, 1'b1, 8'h03, 2'd2);
        drain_wait();

        // Reset in the middle of a packet discards it.
        send(4'hF, 4'hF, 3'd7, 1'b0, 1'b0, 8'h00, 2'd0);
        send(4'hF, 4'hF, 3'd7, 1'b0, 1'b0, 8'h00, 2'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        send(4'h2, 4'h2, 3'd7, 1'b1, 1'b1, 8'h02, 2'd1);
        drain_wait();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
